// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and protocol byte constants for the UART program loader.
//   state_e   : loader FSM states
//   SYNC_CODE : default packet start marker
//   ACK_CODE  : default success response byte
//   NAK_CODE  : default error response byte
package uart_pkg;
    typedef enum logic [2:0] {IDLE, ADDR, LEN, DATA, CSUM, RESP} state_e;
    localparam logic [7:0] SYNC_CODE = 8'hA5;
    localparam logic [7:0] ACK_CODE  = 8'h06;
    localparam logic [7:0] NAK_CODE  = 8'h15;
endpackage

// File: rtl/uart_loader_packer.sv
// uart_loader_packer: assembles little-endian data bytes into 32-bit memory writes.
//   cpu_clk, rst  : clock, synchronous active-high reset
//   start         : new packet, restart at word 0 with an empty word
//   abort         : drop any partially assembled word
//   byte_valid    : byte_data is a data byte to pack this cycle
//   last          : byte_data is the final byte of the packet, flush the word
//   wr_en         : allow memory writes (low for a misaligned packet)
//   base          : packet base address (word aligned when wr_en is high)
//   mem_*         : registered single-cycle memory write port
module uart_loader_packer (
    input  logic        cpu_clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    input  logic        last,
    input  logic        wr_en,
    input  logic [31:0] base,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb
);
    logic [1:0]  lane_q, lane_d;
    logic [31:0] word_q, word_d, word_n;
    logic [3:0]  strb_q, strb_d, strb_n;
    logic [29:0] widx_q, widx_d;
    logic        mem_we_d;
    logic [31:0] mem_addr_d, mem_wdata_d;
    logic [3:0]  mem_wstrb_d;

    always_comb begin
        word_n      = word_q | ({24'd0, byte_data} << {lane_q, 3'b000});
        strb_n      = strb_q | (4'b0001 << lane_q);
        lane_d      = lane_q;
        word_d      = word_q;
        strb_d      = strb_q;
        widx_d      = widx_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        mem_wstrb_d = '0;
        if (start || abort) begin
            lane_d = '0;
            word_d = '0;
            strb_d = '0;
            widx_d = start ? '0 : widx_q;
        end else if (byte_valid) begin
            if (lane_q == 2'd3 || last) begin
                // Bus stays all-zero when writes are suppressed so nothing stale is visible.
                if (wr_en) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = base + {widx_q, 2'b00};
                    mem_wdata_d = word_n;
                    mem_wstrb_d = strb_n;
                end
                lane_d = '0;
                word_d = '0;
                strb_d = '0;
                widx_d = widx_q + 30'd1;
            end else begin
                lane_d = lane_q + 2'd1;
                word_d = word_n;
                strb_d = strb_n;
            end
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (rst) begin
            lane_q    <= '0;
            word_q    <= '0;
            strb_q    <= '0;
            widx_q    <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else begin
            lane_q    <= lane_d;
            word_q    <= word_d;
            strb_q    <= strb_d;
            widx_q    <= widx_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            mem_wstrb <= mem_wstrb_d;
        end
    end
endmodule

// File: rtl/uart_loader.sv
// uart_loader: boot-time loader parsing framed UART packets into memory writes.
//   cpu_clk, rst          : clock, synchronous active-high reset
//   r_ready, r_data_out   : receive FIFO non-empty flag and head byte
//   r_overflow            : sticky receive overflow, forces a NAK mid-packet
//   r_enable              : pop the receive FIFO this cycle
//   w_ready, w_enable     : transmit FIFO space / push strobe
//   w_data_in             : response byte (ACK or NAK)
//   mem_we/addr/wdata/wstrb : single-cycle memory write port
//   loading               : high from sync accepted until response pushed
//   done                  : one-cycle pulse after an ACK is pushed
// Packet: SYNC, addr[4] LE, len[2] LE, data[len], csum (8-bit sum of addr, len and data bytes).
module uart_loader
    import uart_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0] SYNC_BYTE      = SYNC_CODE,
    parameter logic [7:0] ACK_BYTE       = ACK_CODE,
    parameter logic [7:0] NAK_BYTE       = NAK_CODE
) (
    input  logic        cpu_clk,
    input  logic        rst,
    input  logic        r_ready,
    input  logic [7:0]  r_data_out,
    input  logic        r_overflow,
    output logic        r_enable,
    input  logic        w_ready,
    output logic        w_enable,
    output logic [7:0]  w_data_in,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    output logic        loading,
    output logic        done
);
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] base_q, base_d;
    logic [15:0] len_q, len_d;
    logic [15:0] dcnt_q, dcnt_d;
    logic [7:0]  csum_q, csum_d;
    logic        err_q, err_d;
    logic        mis_q, mis_d;
    logic [31:0] tmo_q, tmo_d;
    logic        loading_q, loading_d;
    logic        done_q, done_d;
    logic        active, pk_start, pk_abort, pk_valid, pk_last;

    assign r_enable  = r_ready && state_q != RESP;
    assign w_enable  = state_q == RESP && w_ready;
    assign w_data_in = w_enable ? (err_q ? NAK_BYTE : ACK_BYTE) : 8'h00;
    assign loading   = loading_q;
    assign done      = done_q;

    always_comb begin
        active    = state_q inside {ADDR, LEN, DATA, CSUM};
        state_d   = state_q;
        cnt_d     = cnt_q;
        base_d    = base_q;
        len_d     = len_q;
        dcnt_d    = dcnt_q;
        csum_d    = csum_q;
        err_d     = err_q;
        mis_d     = mis_q;
        tmo_d     = active ? (r_enable ? '0 : tmo_q + 32'd1) : '0;
        loading_d = loading_q;
        done_d    = 1'b0;
        pk_start  = 1'b0;
        pk_abort  = 1'b0;
        pk_valid  = 1'b0;
        pk_last   = 1'b0;
        if (state_q != IDLE && r_overflow)
            err_d = 1'b1;
        case (state_q)
            IDLE: if (r_enable && r_data_out == SYNC_BYTE) begin
                state_d   = ADDR;
                cnt_d     = '0;
                csum_d    = '0;
                err_d     = 1'b0;
                mis_d     = 1'b0;
                loading_d = 1'b1;
                pk_start  = 1'b1;
            end
            ADDR: if (r_enable) begin
                base_d = {r_data_out, base_q[31:8]};
                csum_d = csum_q + r_data_out;
                cnt_d  = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = LEN;
                    if (base_d[1:0] != 2'b00) begin
                        err_d = 1'b1;
                        mis_d = 1'b1;
                    end
                end
            end
            LEN: if (r_enable) begin
                len_d  = {r_data_out, len_q[15:8]};
                csum_d = csum_q + r_data_out;
                cnt_d  = cnt_q + 2'd1;
                dcnt_d = '0;
                if (cnt_q == 2'd1) begin
                    cnt_d   = '0;
                    state_d = len_d == 16'd0 ? CSUM : DATA;
                end
            end
            DATA: begin
                pk_valid = r_enable;
                pk_last  = dcnt_q == len_q - 16'd1;
                if (r_enable) begin
                    csum_d  = csum_q + r_data_out;
                    dcnt_d  = dcnt_q + 16'd1;
                    state_d = pk_last ? CSUM : DATA;
                end
            end
            CSUM: if (r_enable) begin
                if (r_data_out != csum_q)
                    err_d = 1'b1;
                state_d = RESP;
            end
            RESP: if (w_ready) begin
                state_d   = IDLE;
                loading_d = 1'b0;
                done_d    = !err_q;
            end
            default: state_d = IDLE;
        endcase
        // A byte arriving on the deadline cycle still counts; only a silent cycle aborts.
        if (active && !r_enable && tmo_q == TMO_LAST) begin
            err_d    = 1'b1;
            state_d  = RESP;
            tmo_d    = '0;
            pk_abort = 1'b1;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            base_q    <= '0;
            len_q     <= '0;
            dcnt_q    <= '0;
            csum_q    <= '0;
            err_q     <= 1'b0;
            mis_q     <= 1'b0;
            tmo_q     <= '0;
            loading_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            base_q    <= base_d;
            len_q     <= len_d;
            dcnt_q    <= dcnt_d;
            csum_q    <= csum_d;
            err_q     <= err_d;
            mis_q     <= mis_d;
            tmo_q     <= tmo_d;
            loading_q <= loading_d;
            done_q    <= done_d;
        end
    end

    uart_loader_packer u_packer (
        .cpu_clk    (cpu_clk),
        .rst        (rst),
        .start      (pk_start),
        .abort      (pk_abort),
        .byte_valid (pk_valid),
        .byte_data  (r_data_out),
        .last       (pk_last),
        .wr_en      (!mis_q),
        .base       (base_q),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb)
    );
endmodule

// File: tb/tb_uart_loader.sv
// tb_uart_loader: table-driven packet bench with write/response scoreboard for uart_loader.
module tb_uart_loader;
    logic        cpu_clk = 1'b0;
    logic        rst = 1'b1;
    logic        r_ready = 1'b0;
    logic [7:0]  r_data_out = 8'h00;
    logic        r_overflow = 1'b0;
    logic        r_enable;
    logic        w_ready = 1'b1;
    logic        w_enable;
    logic [7:0]  w_data_in;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        loading, done;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_t;

    typedef struct {
        logic [31:0] base;
        int          n;
        logic [7:0]  seed;
        logic [7:0]  step;
        bit          bad;
        bit          ovf;
        bit          junk;
    } vec_t;

    wr_t        exp_wr[$];
    logic [7:0] exp_rsp[$];
    vec_t       vecs[8];
    int         n_cmp = 0;
    int         n_bad = 0;
    bit         prev_ack = 1'b0;

    always #5 cpu_clk = ~cpu_clk;

    uart_loader #(.TIMEOUT_CYCLES(16)) dut (
        .cpu_clk    (cpu_clk),
        .rst        (rst),
        .r_ready    (r_ready),
        .r_data_out (r_data_out),
        .r_overflow (r_overflow),
        .r_enable   (r_enable),
        .w_ready    (w_ready),
        .w_enable   (w_enable),
        .w_data_in  (w_data_in),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .loading    (loading),
        .done       (done)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Scoreboard monitor: pops expectations whenever the DUT produces a write or response.
    always @(negedge cpu_clk) begin
        #2;
        if (!rst) begin
            if (prev_ack)
                chk("done_pulse", {31'd0, done}, 32'd1);
            else if (done)
                chk("done_spurious", {31'd0, done}, 32'd0);
            prev_ack = 1'b0;
            if (mem_we) begin
                if (exp_wr.size() == 0) begin
                    chk("unexpected_write", mem_addr, 32'hxxxx_xxxx);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    chk("mem_addr", mem_addr, e.addr);
                    chk("mem_wdata", mem_wdata, e.data);
                    chk("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, e.strb});
                end
            end
            if (w_enable) begin
                if (exp_rsp.size() == 0) begin
                    chk("unexpected_resp", {24'd0, w_data_in}, 32'hxxxx_xxxx);
                end else begin
                    logic [7:0] r;
                    r = exp_rsp.pop_front();
                    chk("resp_byte", {24'd0, w_data_in}, {24'd0, r});
                    prev_ack = r == 8'h06;
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge following the accepting posedge.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        r_ready    = 1'b1;
        r_data_out = b;
        #1;
        while (!r_enable && n < 50) begin
            @(negedge cpu_clk);
            #1;
            n++;
        end
        if (!r_enable)
            chk("pop_timeout", 32'd0, 32'd1);
        @(negedge cpu_clk);
        r_ready = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_wr.size() != 0 || exp_rsp.size() != 0) && n < 200) begin
            @(negedge cpu_clk);
            n++;
        end
        chk(name, exp_wr.size() + exp_rsp.size(), 32'd0);
        repeat (2) @(negedge cpu_clk);
        chk("loading_after", {31'd0, loading}, 32'd0);
    endtask

    task automatic send_packet(input vec_t v);
        logic [7:0]  bytes[$];
        logic [7:0]  cs;
        logic [15:0] n16;
        logic [7:0]  d;
        wr_t         w;
        bytes = {};
        cs    = 8'h00;
        n16   = 16'(v.n);
        if (v.junk) begin
            bytes.push_back(8'h00);
            bytes.push_back(8'hFF);
        end
        bytes.push_back(8'hA5);
        for (int i = 0; i < 4; i++) begin
            bytes.push_back(v.base[8*i +: 8]);
            cs += v.base[8*i +: 8];
        end
        bytes.push_back(n16[7:0]);
        bytes.push_back(n16[15:8]);
        cs += n16[7:0] + n16[15:8];
        for (int i = 0; i < v.n; i++) begin
            d = v.seed + 8'(i) * v.step;
            bytes.push_back(d);
            cs += d;
        end
        bytes.push_back(v.bad ? cs + 8'd1 : cs);
        if (v.base[1:0] == 2'b00) begin
            for (int k = 0; k < (v.n + 3) / 4; k++) begin
                w.addr = v.base + 32'(4 * k);
                w.data = '0;
                w.strb = '0;
                for (int j = 0; j < 4; j++) begin
                    if (4 * k + j < v.n) begin
                        w.data[8*j +: 8] = v.seed + 8'(4 * k + j) * v.step;
                        w.strb[j] = 1'b1;
                    end
                end
                exp_wr.push_back(w);
            end
        end
        exp_rsp.push_back((v.bad || v.ovf || v.base[1:0] != 2'b00) ? 8'h15 : 8'h06);
        for (int i = 0; i < bytes.size(); i++) begin
            send_byte(bytes[i]);
            if (bytes[i] == 8'hA5 && v.ovf && i < 3)
                r_overflow = 1'b1;
        end
        r_overflow = 1'b0;
        drain("drain_packet");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{32'h0000_1000, 4,  8'h11, 8'h11, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'h0000_2000, 6,  8'h01, 8'h01, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{32'h0000_1000, 4,  8'h11, 8'h11, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{32'h0000_1002, 4,  8'h11, 8'h11, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{32'h0000_0000, 0,  8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{32'hFFFF_FFFC, 8,  8'hA5, 8'h01, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{32'h0000_4000, 5,  8'h07, 8'h09, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{32'h0000_8000, 13, 8'h30, 8'h01, 1'b0, 1'b0, 1'b0};

        repeat (3) @(negedge cpu_clk);
        chk("rst_loading", {31'd0, loading}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
        chk("rst_w_enable", {31'd0, w_enable}, 32'd0);
        chk("rst_w_data_in", {24'd0, w_data_in}, 32'd0);
        chk("rst_r_enable", {31'd0, r_enable}, 32'd0);
        rst = 1'b0;
        @(negedge cpu_clk);

        for (int i = 0; i < 8; i++)
            send_packet(vecs[i]);

        // Timeout with transmit backpressure: 2 of 8 data bytes, then silence.
        w_ready = 1'b0;
        exp_rsp.push_back(8'h15);
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h30);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h08);
        send_byte(8'h00);
        send_byte(8'hDE);
        send_byte(8'hAD);
        repeat (26) begin
            @(negedge cpu_clk);
            #1;
            chk("tmo_loading", {31'd0, loading}, 32'd1);
            chk("tmo_no_push", {31'd0, w_enable}, 32'd0);
        end
        w_ready = 1'b1;
        #1;
        chk("tmo_push", {31'd0, w_enable}, 32'd1);
        chk("tmo_nak", {24'd0, w_data_in}, 32'h15);
        @(negedge cpu_clk);
        drain("drain_timeout");

        // Reset mid-packet: nothing written, no response, next packet unaffected.
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h10);
        chk("mid_loading", {31'd0, loading}, 32'd1);
        rst = 1'b1;
        @(negedge cpu_clk);
        rst = 1'b0;
        chk("mid_rst_loading", {31'd0, loading}, 32'd0);
        repeat (3) @(negedge cpu_clk);
        send_packet(vecs[1]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
